seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a NUM_DIGITS-digit common-anode 7-segment display.
- Latches a packed nibble vector and scans one digit at a time.
- Decodes each digit in decimal or hex mode, with optional leading-zero blanking.
- Sits between game/score logic and the board display pins.
- Generalised successor of the single-digit registered decoder: multi-digit, hex-capable, tear-free update.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- SCAN_DIV, 50000: clk cycles each digit is held active (>=2).
- BLINK_FRAMES, 32: full scan frames per blink half-period; used only with SEG7_BLINK_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- digits_in  in  4*NUM_DIGITS  packed nibbles; [3:0] is digit 0, the least significant digit.
- load  in  1  capture strobe for digits_in and dp_in.
- dp_in  in  NUM_DIGITS  per-digit decimal point, 1 = lit.
- hex_en  in  1  1 = hex decode of values 10..15; 0 = decimal decode.
- blank_lz  in  1  1 = blank leading zeros.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp_out  out  1  decimal point, active-low, registered.
- an_out  out  NUM_DIGITS  digit enables, one-hot active-low, registered.
- frame_done  out  1  one-cycle pulse on scan wrap.

Behaviour:
- Reset (rst=0, async)
  - seg_out=7'h7F, dp_out=1, an_out=all 1s (display dark), frame_done=0.
  - Scan counter=0, digit index=0.
  - Pending and active registers cleared to 0, dp registers to 0.
  - Reset mid-scan aborts immediately. The first digit enabled after reset is digit 0.
- Scan counter
  - Counts 0..SCAN_DIV-1 and wraps.
  - At terminal count the index advances. It wraps from NUM_DIGITS-1 to 0.
- Frame boundary = terminal count while index = NUM_DIGITS-1.
  - frame_done=1 for exactly the next cycle.
- Output registers
  - an_out, seg_out and dp_out update together, 1 cycle after the index changes.
  - They never show mismatched digit/segment data.
- Data capture (tear-free)
  - load=1 copies digits_in/dp_in into pending.
  - Pending copies to active only at a frame boundary, so a frame never mixes old and new data.
  - Simultaneous load and frame boundary: digits_in goes straight to active.
  - Multiple loads within one frame: the last wins.
- Decode (active-low)
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - hex_en=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - hex_en=0 and value 10..15: dash 0111111.
  - hex_en and blank_lz are sampled live each digit slot, not captured by load.
- Leading-zero blanking (blank_lz=1)
  - Digits above the most significant non-zero active digit show 1111111 with dp_out=1.
  - Digit 0 is never blanked, so all zeros displays "0".
  - A dp_in bit does not prevent blanking.
- Decimal point: dp_out = ~dp_active[index], unless the digit is blanked.

Optional Feature:
- Macro SEG7_BLINK_EN.
- Defined:
  - Adds input blink_mask, width NUM_DIGITS, captured with load via pending/active like the digits.
  - An internal frame counter toggles blink phase every BLINK_FRAMES frames.
  - While phase=1, masked digits drive seg_out=1111111 and dp_out=1; an_out still scans.
  - Phase resets to 0.
- Not defined: no blink_mask port, no frame counter; behaviour identical to phase=0.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4 unless stated):
- Reset release, no load:
  - an_out walks 1110→1101→1011→0111, 4 cycles each, first change 1 cycle after the first terminal count.
  - seg_out=1000000 on every digit.
  - frame_done pulses once every 16 cycles.
- load digits_in=16'h1234, hex_en=0, blank_lz=0:
  - Unchanged until the next frame boundary.
  - Then digit 0 slot seg=0011001 ("4"), digit 3 slot seg=1111001 ("1").
- digits_in=16'h00AF:
  - hex_en=1, blank_lz=1: digit 0=0001110, digit 1=0001000, digits 2-3=1111111.
  - hex_en=0: digits 0-1=0111111.
- digits_in=0, blank_lz=1, dp_in=4'b0100: digits 1-3 blank with dp_out=1; digit 0 shows 1000000.
- Tear-free update:
  - load 16'h1111, then 16'h2222 mid-frame: the next frame shows only "2222".
  - load coincident with the frame boundary: takes effect in that same next frame.
- Async rst pulse mid-digit: outputs go dark within the same cycle; scan restarts at digit 0. With SEG7_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001: digit 0 dark on alternating 2-frame periods.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned (tear-free) data update.
// Define SEG7_BLINK_EN to add the blink_mask input and a frame-based blink phase.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      load,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      hex_en,
  input  logic                      blank_lz,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]                seg_out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     an_out,
  output logic                      frame_done
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_DARK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_params
    $error("seg7_scan_driver: parameter out of range");
  end

  // Active-low {g,f,e,d,c,b,a} pattern for one nibble
  function automatic logic [6:0] decode_digit(input logic [3:0] val, input logic hex);
    logic [6:0] seg;
    case (val)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = hex ? 7'b0001000 : SEG_DASH;
      4'hB:    seg = hex ? 7'b0000011 : SEG_DASH;
      4'hC:    seg = hex ? 7'b1000110 : SEG_DASH;
      4'hD:    seg = hex ? 7'b0100001 : SEG_DASH;
      4'hE:    seg = hex ? 7'b0000110 : SEG_DASH;
      default: seg = hex ? 7'b0001110 : SEG_DASH;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0][3:0] act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]      act_dp_q, act_dp_d;
  logic                       term_cnt, frame_end;

  logic [NUM_DIGITS-1:0]      zero_above;
  logic [3:0]                 cur_val;
  logic                       blanked, blink_off, all_zero;
  logic [6:0]                 seg_d;
  logic                       dp_d;
  logic [NUM_DIGITS-1:0]      an_d;

  // Next-state: scan position and pending/active data banks
  always_comb begin
    term_cnt   = (cnt_q == CNT_LAST);
    frame_end  = term_cnt && (idx_q == IDX_LAST);
    cnt_d      = term_cnt ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (term_cnt) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    pend_dig_d = load ? digits_in : pend_dig_q;
    pend_dp_d  = load ? dp_in : pend_dp_q;
    // pend_*_d already holds digits_in on a coincident load, so it lands in this frame
    act_dig_d  = frame_end ? pend_dig_d : act_dig_q;
    act_dp_d   = frame_end ? pend_dp_d : act_dp_q;
  end

  // Output decode for the digit currently selected by idx_q
  always_comb begin
    all_zero   = 1'b1;
    zero_above = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      all_zero      = all_zero & (act_dig_q[i] == 4'h0);
      zero_above[i] = all_zero;
    end
    cur_val = act_dig_q[idx_q];
    blanked = blank_lz && (idx_q != '0) && zero_above[idx_q];
    an_d    = '1;
    an_d[idx_q] = 1'b0;
    if (blanked || blink_off) begin
      seg_d = SEG_DARK;
      dp_d  = 1'b1;
    end else begin
      seg_d = decode_digit(cur_val, hex_en);
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      act_dig_q  <= '0;
      pend_dp_q  <= '0;
      act_dp_q   <= '0;
      seg_out    <= SEG_DARK;
      dp_out     <= 1'b1;
      an_out     <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      act_dig_q  <= act_dig_d;
      pend_dp_q  <= pend_dp_d;
      act_dp_q   <= act_dp_d;
      seg_out    <= seg_d;
      dp_out     <= dp_d;
      an_out     <= an_d;
      frame_done <= frame_end;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] pend_blk_q, pend_blk_d;
  logic [NUM_DIGITS-1:0] act_blk_q, act_blk_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;

  // Blink mask follows the same pending/active path; phase flips every BLINK_FRAMES frames
  always_comb begin
    pend_blk_d = load ? blink_mask : pend_blk_q;
    act_blk_d  = frame_end ? pend_blk_d : act_blk_q;
    fcnt_d     = fcnt_q;
    phase_d    = phase_q;
    if (frame_end) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_blk_q <= '0;
      act_blk_q  <= '0;
      fcnt_q     <= '0;
      phase_q    <= 1'b0;
    end else begin
      pend_blk_q <= pend_blk_d;
      act_blk_q  <= act_blk_d;
      fcnt_q     <= fcnt_d;
      phase_q    <= phase_d;
    end
  end

  assign blink_off = phase_q & act_blk_q[idx_q];
`else
  assign blink_off = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2).
// Reference model works from elapsed cycles since reset and frame-level data capture.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * SD;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   digits_in;
  logic          load;
  logic [3:0]    dp_in;
  logic          hex_en;
  logic          blank_lz;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [3:0]    an_out;
  logic          frame_done;
`ifdef SEG7_BLINK_EN
  logic [3:0]    blink_mask;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int          k;
  logic [15:0] pend_m, act_m;
  logic [3:0]  pdp_m, adp_m, pblk_m, ablk_m;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;
  logic [3:0]  exp_an;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .load       (load),
    .dp_in      (dp_in),
    .hex_en     (hex_en),
    .blank_lz   (blank_lz),
`ifdef SEG7_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] v, input logic hex);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: begin
        if (!hex) return 7'b0111111;
        case (v)
          4'd10:   return 7'b0001000;
          4'd11:   return 7'b0000011;
          4'd12:   return 7'b1000110;
          4'd13:   return 7'b0100001;
          4'd14:   return 7'b0000110;
          default: return 7'b0001110;
        endcase
      end
    endcase
  endfunction

  task automatic model_reset();
    k = 0;
    pend_m = '0; act_m = '0;
    pdp_m = '0; adp_m = '0; pblk_m = '0; ablk_m = '0;
    exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fd = 1'b0;
  endtask

  // Expected outputs after the coming edge, then the data capture that edge performs
  task automatic model_edge();
    int d;
    logic [15:0] above;
    logic blank, off;
    k++;
    d = ((k - 1) / SD) % N;
    above = act_m >> (4 * d);
    blank = blank_lz && (d != 0) && (above == 16'h0);
`ifdef SEG7_BLINK_EN
    off = ((((k - 1) / FRAME) / BF) % 2 == 1) && ablk_m[d];
`else
    off = 1'b0;
`endif
    exp_an  = ~(4'b0001 << d);
    exp_seg = (blank || off) ? 7'h7F : seg_ref(above[3:0], hex_en);
    exp_dp  = (blank || off) ? 1'b1 : ~adp_m[d];
    exp_fd  = (k % FRAME) == 0;
    if ((k % FRAME) == 0) begin
      act_m  = load ? digits_in : pend_m;
      adp_m  = load ? dp_in : pdp_m;
`ifdef SEG7_BLINK_EN
      ablk_m = load ? blink_mask : pblk_m;
`endif
    end
    if (load) begin
      pend_m = digits_in;
      pdp_m  = dp_in;
`ifdef SEG7_BLINK_EN
      pblk_m = blink_mask;
`endif
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; hex_en = 1'b0; blank_lz = 1'b0;
`ifdef SEG7_BLINK_EN
    blink_mask = '0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({seg_out, dp_out, an_out, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0})
      $display("FAIL reset_dark got seg=%b dp=%b an=%b fd=%b want 1111111/1/1111/0", seg_out, dp_out, an_out, frame_done);
    else n_pass++;
    rst = 1'b1;
    pulses = 0;
    for (int t = 0; t < 3 * FRAME; t++) begin
      tick();
      if (frame_done === 1'b1) pulses++;
      n_checks++;
      if ({seg_out, dp_out, an_out, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd})
        $display("FAIL reset_scan k=%0d got seg=%b dp=%b an=%b fd=%b want seg=%b dp=%b an=%b fd=%b",
                 k, seg_out, dp_out, an_out, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      else n_pass++;
    end
    n_checks++;
    if (pulses !== 3) $display("FAIL frame_done_count got %0d want 3", pulses);
    else n_pass++;
  endtask

  task automatic test_decimal();
    logic [6:0] want [N];
    want = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    hex_en = 1'b0; blank_lz = 1'b0; dp_in = 4'b0000;
    digits_in = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (FRAME - (k % FRAME)) begin
      tick();
      n_checks++;
      if ({seg_out, dp_out, an_out, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd})
        $display("FAIL decimal_hold k=%0d got seg=%b an=%b fd=%b want seg=%b an=%b fd=%b",
                 k, seg_out, an_out, frame_done, exp_seg, exp_an, exp_fd);
      else n_pass++;
    end
    for (int t = 0; t < FRAME; t++) begin
      tick();
      n_checks++;
      if ({seg_out, dp_out, an_out, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd})
        $display("FAIL decimal_scan k=%0d got seg=%b an=%b want seg=%b an=%b", k, seg_out, an_out, exp_seg, exp_an);
      else n_pass++;
      if (t % SD == 0) begin
        n_checks++;
        if (seg_out !== want[t / SD] || an_out !== ~(4'b0001 << (t / SD)))
          $display("FAIL decimal_digit%0d got seg=%b an=%b want seg=%b", t / SD, seg_out, an_out, want[t / SD]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hex_blank();
    logic [6:0] want_hex [N];
    logic [6:0] want_dec [N];
    want_hex = '{7'b0001110, 7'b0001000, 7'h7F, 7'h7F};
    want_dec = '{7'b0111111, 7'b0111111, 7'h7F, 7'h7F};
    hex_en = 1'b1; blank_lz = 1'b1;
    digits_in = 16'h00AF; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (FRAME - (k % FRAME)) tick();
    for (int pass = 0; pass < 2; pass++) begin
      for (int t = 0; t < FRAME; t++) begin
        tick();
        n_checks++;
        if ({seg_out, dp_out, an_out, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd})
          $display("FAIL hex_scan k=%0d got seg=%b dp=%b want seg=%b dp=%b", k, seg_out, dp_out, exp_seg, exp_dp);
        else n_pass++;
        if (t % SD == 0) begin
          n_checks++;
          if (seg_out !== ((pass == 0) ? want_hex[t / SD] : want_dec[t / SD]))
            $display("FAIL hex_digit%0d hex_en=%b got seg=%b want seg=%b", t / SD, hex_en, seg_out,
                     (pass == 0) ? want_hex[t / SD] : want_dec[t / SD]);
          else n_pass++;
        end
      end
      hex_en = 1'b0;
    end
  endtask

  task automatic test_zero_dp();
    logic [6:0] want [N];
    want = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F};
    hex_en = 1'b0; blank_lz = 1'b1;
    digits_in = 16'h0000; dp_in = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (FRAME - (k % FRAME)) tick();
    for (int t = 0; t < FRAME; t++) begin
      tick();
      if (t % SD == 0) begin
        n_checks++;
        if (seg_out !== want[t / SD] || dp_out !== 1'b1)
          $display("FAIL zero_digit%0d got seg=%b dp=%b want seg=%b dp=1", t / SD, seg_out, dp_out, want[t / SD]);
        else n_pass++;
      end
    end
    dp_in = 4'b0000;
  endtask

  task automatic test_tear_free();
    logic [6:0] want [N];
    blank_lz = 1'b0; hex_en = 1'b0;
    repeat (3) tick();
    digits_in = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    digits_in = 16'h2222; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (FRAME - (k % FRAME)) begin
      tick();
      n_checks++;
      if ({seg_out, dp_out, an_out, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd})
        $display("FAIL tear_hold k=%0d got seg=%b an=%b want seg=%b an=%b", k, seg_out, an_out, exp_seg, exp_an);
      else n_pass++;
    end
    for (int t = 0; t < FRAME; t++) begin
      tick();
      n_checks++;
      if (seg_out !== 7'b0100100)
        $display("FAIL tear_new_frame k=%0d got seg=%b want seg=0100100", k, seg_out);
      else n_pass++;
    end
    // Load landing on the frame-boundary edge itself
    repeat (FRAME - 1) tick();
    want = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
    digits_in = 16'h5678; load = 1'b1;
    tick();
    load = 1'b0;
    for (int t = 0; t < FRAME; t++) begin
      tick();
      if (t % SD == 0) begin
        n_checks++;
        if (seg_out !== want[t / SD])
          $display("FAIL coincident_digit%0d got seg=%b want seg=%b", t / SD, seg_out, want[t / SD]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] mask;
    for (int t = 0; t < 800; t++) begin
      load = ($urandom_range(7) == 0);
      mask = 16'hFFFF >> (4 * $urandom_range(3));
      digits_in = 16'($urandom) & mask;
      dp_in = 4'($urandom);
`ifdef SEG7_BLINK_EN
      blink_mask = 4'($urandom);
`endif
      if ($urandom_range(15) == 0) hex_en = ~hex_en;
      if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
      tick();
      n_checks++;
      if ({seg_out, dp_out, an_out, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd})
        $display("FAIL random k=%0d got seg=%b dp=%b an=%b fd=%b want seg=%b dp=%b an=%b fd=%b",
                 k, seg_out, dp_out, an_out, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      else n_pass++;
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    repeat ($urandom_range(40, 1)) tick();
    blank_lz = 1'b0; hex_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({seg_out, dp_out, an_out, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0})
      $display("FAIL reset_mid_dark got seg=%b dp=%b an=%b fd=%b want 1111111/1/1111/0", seg_out, dp_out, an_out, frame_done);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < FRAME; t++) begin
      tick();
      n_checks++;
      if ({seg_out, dp_out, an_out, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd})
        $display("FAIL reset_mid_scan k=%0d got seg=%b dp=%b an=%b want seg=%b dp=%b an=%b",
                 k, seg_out, dp_out, an_out, exp_seg, exp_dp, exp_an);
      else n_pass++;
      if (t == 0) begin
        n_checks++;
        if (an_out !== 4'b1110 || seg_out !== 7'b1000000)
          $display("FAIL reset_mid_first got an=%b seg=%b want an=1110 seg=1000000", an_out, seg_out);
        else n_pass++;
      end
    end
  endtask

`ifdef SEG7_BLINK_EN
  task automatic test_blink();
    int f;
    logic [6:0] want0;
    digits_in = 16'h1234; dp_in = 4'b0000; blink_mask = 4'b0001; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (FRAME - (k % FRAME)) tick();
    for (int fr = 0; fr < 6; fr++) begin
      f = k / FRAME;
      want0 = (((f / BF) % 2) == 1) ? 7'h7F : 7'b0011001;
      for (int t = 0; t < FRAME; t++) begin
        tick();
        n_checks++;
        if ({seg_out, dp_out, an_out, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd})
          $display("FAIL blink_scan k=%0d got seg=%b dp=%b an=%b want seg=%b dp=%b an=%b",
                   k, seg_out, dp_out, an_out, exp_seg, exp_dp, exp_an);
        else n_pass++;
        if (t == 0) begin
          n_checks++;
          if (seg_out !== want0 || an_out !== 4'b1110)
            $display("FAIL blink_digit0 frame=%0d got seg=%b an=%b want seg=%b an=1110", f, seg_out, an_out, want0);
          else n_pass++;
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_decimal();
    test_hex_blank();
    test_zero_dp();
    test_tear_free();
    test_random();
    test_reset_mid();
`ifdef SEG7_BLINK_EN
    test_blink();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
